// File: rtl/ascon_init_ctrl_if.sv
// Job/result handshake bundle for the ASCON initialization sequencer.
// master = job issuer and state consumer, slave = the sequencer itself.
interface ascon_init_ctrl_if;
    logic         start_valid;
    logic         start_ready;
    logic [1:0]   sel_type;
    logic [127:0] key;
    logic [127:0] nonce;
    logic         out_valid;
    logic         out_ready;
    logic [319:0] out_state;

    modport master (
        output start_valid, sel_type, key, nonce, out_ready,
        input  start_ready, out_valid, out_state
    );

    modport slave (
        input  start_valid, sel_type, key, nonce, out_ready,
        output start_ready, out_valid, out_state
    );
endinterface

// File: rtl/ascon_init_ctrl.sv
// ASCON initialization sequencer: load {IV,K,N}, run NROUNDS rounds, fold K.
// Optional ASCON_INIT_ZEROIZE_EN clears state/key after the output handshake.
module ascon_init_ctrl #(
    parameter int NROUNDS = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    ascon_init_ctrl_if.slave    bus,
    output logic                rnd_en_o,
    output logic [319:0]        rnd_state_o,
    output logic [7:0]          rnd_rc_o,
    input  logic [319:0]        rnd_state_i,
    output logic                busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [63:0] IV_AEAD = 64'h00001000808c0001;
    localparam logic [63:0] IV_HASH = 64'h0000080100cc0002;
    localparam logic [63:0] IV_XOF  = 64'h0000080000cc0003;
    localparam logic [63:0] IV_CXOF = 64'h0000080000cc0004;

    localparam logic [3:0] LAST_RND = 4'(NROUNDS - 1);
    localparam logic [7:0] RC_BASE  = 8'(12 - NROUNDS);

    logic [1:0]   fsm_q;
    logic [3:0]   rnd_cnt_q;
    logic [319:0] state_q;
    logic [127:0] key_q;

    logic [63:0]  iv;
    logic         is_aead;
    logic [127:0] key_in;
    logic [127:0] nonce_in;
    logic [7:0]   rc_idx;

    always_comb begin
        iv = IV_AEAD;
        unique case (bus.sel_type)
            2'b00:   iv = IV_AEAD;
            2'b01:   iv = IV_HASH;
            2'b10:   iv = IV_XOF;
            default: iv = IV_CXOF;
        endcase
    end

    // Only AEAD128 carries key/nonce; other modes start from a zero K||N.
    assign is_aead  = (bus.sel_type == 2'b00);
    assign key_in   = is_aead ? bus.key   : '0;
    assign nonce_in = is_aead ? bus.nonce : '0;

    assign rc_idx = RC_BASE + {4'b0, rnd_cnt_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= S_IDLE;
            rnd_cnt_q <= '0;
            state_q   <= '0;
            key_q     <= '0;
        end else begin
            unique case (fsm_q)
                S_IDLE: begin
                    if (bus.start_valid) begin
                        state_q   <= {iv, key_in, nonce_in};
                        key_q     <= key_in;
                        rnd_cnt_q <= '0;
                        fsm_q     <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    state_q <= rnd_state_i;
                    if (rnd_cnt_q == LAST_RND) begin
                        fsm_q <= S_FINAL;
                    end else begin
                        rnd_cnt_q <= rnd_cnt_q + 4'd1;
                    end
                end
                S_FINAL: begin
                    state_q <= state_q ^ {192'b0, key_q};
                    fsm_q   <= S_DONE;
                end
                default: begin
                    if (bus.out_ready) begin
                        fsm_q <= S_IDLE;
`ifdef ASCON_INIT_ZEROIZE_EN
                        state_q <= '0;
                        key_q   <= '0;
`endif
                    end
                end
            endcase
        end
    end

    assign bus.start_ready = (fsm_q == S_IDLE);
    assign busy            = (fsm_q != S_IDLE);
    assign rnd_en_o        = (fsm_q == S_ROUND);
    assign rnd_state_o     = state_q;
    assign rnd_rc_o        = rnd_en_o ? (8'hF0 - rc_idx * 8'h0F) : 8'h00;
    assign bus.out_valid   = (fsm_q == S_DONE);

`ifdef ASCON_INIT_ZEROIZE_EN
    assign bus.out_state = bus.out_valid ? state_q : '0;
`else
    assign bus.out_state = state_q;
`endif

endmodule

// File: tb/tb_ascon_init_ctrl.sv
// Self-checking bench for ascon_init_ctrl with a stubbed rc-XOR round core.
// Expected states come from a mode/key/nonce model using the p12 rc table.
module tb_ascon_init_ctrl;
    localparam int NR = 12;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rnd_en_o;
    logic [319:0] rnd_state_o;
    logic [7:0]   rnd_rc_o;
    logic [319:0] rnd_state_i;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] p12 [12];

    ascon_init_ctrl_if bus ();

    ascon_init_ctrl #(.NROUNDS(NR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .rnd_en_o    (rnd_en_o),
        .rnd_state_o (rnd_state_o),
        .rnd_rc_o    (rnd_rc_o),
        .rnd_state_i (rnd_state_i),
        .busy        (busy)
    );

    assign rnd_state_i = rnd_state_o ^ (320'(rnd_rc_o) << 128);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [319:0] obs,
                       input logic [319:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] iv_of(input logic [1:0] t);
        case (t)
            2'b00:   return 64'h00001000808c0001;
            2'b01:   return 64'h0000080100cc0002;
            2'b10:   return 64'h0000080000cc0003;
            default: return 64'h0000080000cc0004;
        endcase
    endfunction

    function automatic logic [7:0] rc_of(input int r);
        return p12[12 - NR + r];
    endfunction

    function automatic logic [127:0] kp_of(input logic [1:0] t,
                                           input logic [127:0] k);
        return (t == 2'b00) ? k : 128'h0;
    endfunction

    // Stub core XORs each rc into x2's low byte; final K fold on x3/x4.
    function automatic logic [319:0] model(input logic [1:0] t,
                                           input logic [127:0] k,
                                           input logic [127:0] n);
        logic [319:0] s;
        s = {iv_of(t), kp_of(t, k), kp_of(t, n)};
        for (int r = 0; r < NR; r++) s ^= (320'(rc_of(r)) << 128);
        s[127:0] ^= kp_of(t, k);
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_job(input logic [1:0] t, input logic [127:0] k,
                           input logic [127:0] n, input int hold,
                           output logic [319:0] res);
        logic [319:0] exp;
        exp = model(t, k, n);
        chk("idle_ready", bus.start_ready, 1);
        bus.sel_type    = t;
        bus.key         = k;
        bus.nonce       = n;
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        bus.sel_type    = 2'($urandom);
        bus.key         = rnd128();
        bus.nonce       = rnd128();
        bus.out_ready   = 1'($urandom);
        chk("load_state", rnd_state_o, {iv_of(t), kp_of(t, k), kp_of(t, n)});
        chk("round_busy", busy, 1);
        chk("round_ready", bus.start_ready, 0);
        for (int r = 0; r < NR; r++) begin
            chk("round_en", rnd_en_o, 1);
            chk($sformatf("rc%0d", r), rnd_rc_o, rc_of(r));
            chk("round_valid", bus.out_valid, 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        chk("final_en", rnd_en_o, 0);
        chk("final_rc", rnd_rc_o, 0);
        chk("final_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        chk("out_valid", bus.out_valid, 1);
        chk("out_state", bus.out_state, exp);
        for (int h = 0; h < hold; h++) begin
            bus.start_valid = (h == 1);
            bus.sel_type    = 2'($urandom);
            @(posedge clk); #1;
            bus.start_valid = 1'b0;
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_ready", bus.start_ready, 0);
            chk("hold_state", bus.out_state, exp);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("hs_valid", bus.out_valid, 0);
        chk("hs_ready", bus.start_ready, 1);
        chk("hs_busy", busy, 0);
`ifdef ASCON_INIT_ZEROIZE_EN
        chk("post_state", bus.out_state, 0);
        chk("post_key", dut.key_q, 0);
`else
        chk("post_state", bus.out_state, exp);
        chk("post_key", dut.key_q, kp_of(t, k));
`endif
        res = exp;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sready"}, bus.start_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ovalid"}, bus.out_valid, 0);
        chk({tag, "_en"}, rnd_en_o, 0);
        chk({tag, "_rc"}, rnd_rc_o, 0);
        chk({tag, "_rstate"}, rnd_state_o, 0);
        chk({tag, "_ostate"}, bus.out_state, 0);
    endtask

    initial begin
        logic [319:0] res;
        logic [127:0] k2, n2;
        p12 = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
        rst_n           = 1'b0;
        bus.start_valid = 1'b0;
        bus.sel_type    = 2'b00;
        bus.key         = '0;
        bus.nonce       = '0;
        bus.out_ready   = 1'b0;
        #12;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_job(2'b01, rnd128(), rnd128(), 0, res);
        chk("hash_lit", res, {64'h0000080100cc0002, 256'h0});

        k2 = 128'h000102030405060708090a0b0c0d0e0f;
        n2 = 128'h101112131415161718191a1b1c1d1e1f;
        run_job(2'b00, k2, n2, 0, res);
        chk("aead_lit", res, {64'h00001000808c0001, k2,
                              64'h1010101010101010, 64'h1010101010101010});

        run_job(2'b00, rnd128(), rnd128(), 5, res);

        run_job(2'b10, rnd128(), rnd128(), 0, res);
        chk("xof_x0", res[319:256], 64'h0000080000cc0003);
        run_job(2'b11, rnd128(), rnd128(), 0, res);
        chk("cxof_x0", res[319:256], 64'h0000080000cc0004);

        bus.sel_type    = 2'b00;
        bus.key         = rnd128();
        bus.nonce       = rnd128();
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        chk("mid_en", rnd_en_o, 1);
        chk("mid_rc", rnd_rc_o, rc_of(6));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int j = 0; j < 6; j++) begin
            run_job(2'($urandom), rnd128(), rnd128(),
                    int'($urandom_range(0, 3)), res);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
